// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scanner.
// Scan state encoding, frame bundle, active-low glyph table, LZB mask.
package seg7_pkg;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_e;

  // One displayable frame: hex value, dp mask, enable mask.
  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  en;
  } frame_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low g..a, entry 15 first; b and d are lowercase.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  // Digit n is blanked when it and every higher nibble are zero.
  // Digit 0 is never blanked.
  function automatic logic [3:0] lzb_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'h0);
    m[2] = m[3] & (v[11:8] == 4'h0);
    m[1] = m[2] & (v[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: 4-bit nibble to active-low g..a segments (combinational).
// Ports: nibble_i (hex digit), seg_o (segments, 0 = lit).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-seg scanner, guard gap, tear-free update.
// Ports: clk, reset (sync, low), wr/wdata/dp_in/en_in (frame load),
// digi (anodes|dp|seg, all active-low), pending, frame_tick.
// Optional: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [15:0] wdata,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  output logic [11:0] digi,
  output logic        pending,
  output logic        frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] G_START = CW'(SCAN_DIV - GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  scan_state_e   st_q, st_d;
  frame_t        shadow_q, shadow_d;
  frame_t        shown_q, shown_d;
  logic          pend_q, pend_d;
  logic [11:0]   digi_q, digi_d;

  logic          slot_end;
  logic          boundary;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic [3:0]    blank;

  assign slot_end = (cnt_q == LAST);
  assign boundary = (st_q == ST_GUARD) && (idx_q == 2'd3) && slot_end;
  assign nib      = shown_q.val[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble_i (nib),
    .seg_o    (seg)
  );

`ifdef SEG7_LZB_EN
  assign blank = lzb_mask(shown_q.val);
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;
    // State tracks the counter value it will hold next cycle.
    st_d  = (cnt_d >= G_START) ? ST_GUARD : ST_DRIVE;

    shadow_d = shadow_q;
    if (wr) shadow_d = {wdata, dp_in, en_in};

    pend_d = pend_q;
    if (wr) pend_d = 1'b1;
    if (boundary) pend_d = 1'b0;

    // A write landing on the boundary cycle is committed directly.
    shown_d = shown_q;
    if (boundary && (wr || pend_q)) shown_d = shadow_d;

    digi_d = 12'hFFF;
    if (st_q == ST_DRIVE && shown_q.en[idx_q]) begin
      digi_d[11:8] = ANODE_OFF & ~(4'b0001 << idx_q);
      digi_d[7]    = ~shown_q.dp[idx_q];
      digi_d[6:0]  = blank[idx_q] ? SEG_OFF : seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      st_q     <= ST_GUARD;
      shadow_q <= '0;
      shown_q  <= '0;
      pend_q   <= 1'b0;
      digi_q   <= 12'hFFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      st_q     <= st_d;
      shadow_q <= shadow_d;
      shown_q  <= shown_d;
      pend_q   <= pend_d;
      digi_q   <= digi_d;
    end
  end

  assign digi       = digi_q;
  assign pending    = pend_q;
  assign frame_tick = boundary;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench with expected-digi scoreboard queue.
// SCAN_DIV=20, GUARD=4; LZB expectations follow SEG7_LZB_EN.
module tb_seg7_scan_driver;

  localparam int SD = 20;
  localparam int GD = 4;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [15:0] wdata;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic [11:0] digi;
  logic        pending;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] k1_digi;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .wdata      (wdata),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .digi       (digi),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] glyph_on(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Expected digi for frame cycle c (c = 0 is first cycle after commit).
  function automatic logic [11:0] exp_digi(input logic [15:0] v,
    input logic [3:0] dp, input logic [3:0] en, input int c);
    int slot;
    int w;
    logic [3:0] an;
    logic [6:0] sg;
    logic [15:0] hi;
    slot = c / SD;
    w = c % SD;
    if (w >= SD - GD || !en[slot]) return 12'hFFF;
    sg = ~glyph_on(v[slot*4 +: 4]);
`ifdef SEG7_LZB_EN
    hi = v >> (4 * slot);
    if (slot > 0 && hi == 16'h0) sg = 7'h7F;
`else
    hi = 16'h0;
    if (hi != 16'h0) sg = 7'h00;
`endif
    an = 4'hF;
    an[slot] = 1'b0;
    return {an, ~dp[slot], sg};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got,
    input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_set(input logic [15:0] v, input logic [3:0] dp,
    input logic [3:0] en);
    wr = 1'b1;
    wdata = v;
    dp_in = dp;
    en_in = en;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("tick_wait", {15'd0, frame_tick}, 16'd1);
  endtask

  task automatic boundary_edge();
    step();
    wr = 1'b0;
    chk("bnd_digi", {4'd0, digi}, 16'hFFF);
    chk("bnd_pend", {15'd0, pending}, 16'd0);
    chk("bnd_tick", {15'd0, frame_tick}, 16'd0);
  endtask

  // Scans frame cycles 1..79 after a boundary, with up to two writes.
  task automatic run_frame(input logic [15:0] v, input logic [3:0] dp,
    input logic [3:0] en,
    input int wka, input logic [15:0] va, input logic [3:0] dpa,
    input logic [3:0] ena,
    input int wkb, input logic [15:0] vb, input logic [3:0] dpb,
    input logic [3:0] enb);
    logic [11:0] e;
    logic pe;
    for (int c = 0; c < FR - 1; c++) exp_q.push_back(exp_digi(v, dp, en, c));
    for (int k = 1; k < FR; k++) begin
      step();
      wr = 1'b0;
      e = exp_q.pop_front();
      if (k == 1) k1_digi = digi;
      chk($sformatf("digi k%0d", k), {4'd0, digi}, {4'd0, e});
      chk($sformatf("tick k%0d", k), {15'd0, frame_tick},
          {15'd0, k == FR - 1});
      pe = (wka >= 0 && k > wka) || (wkb >= 0 && k > wkb);
      chk($sformatf("pend k%0d", k), {15'd0, pending}, {15'd0, pe});
      if (k == wka) wr_set(va, dpa, ena);
      if (k == wkb) wr_set(vb, dpb, enb);
    end
  endtask

  initial begin
    reset = 1'b0;
    wr = 1'b0;
    wdata = 16'h0;
    dp_in = 4'h0;
    en_in = 4'h0;
    step();
    step();
    chk("rst_digi", {4'd0, digi}, 16'hFFF);
    chk("rst_pend", {15'd0, pending}, 16'd0);
    chk("rst_tick", {15'd0, frame_tick}, 16'd0);

    reset = 1'b1;
    wr_set(16'h1234, 4'h0, 4'hF);
    step();
    wr = 1'b0;
    chk("pend_wr", {15'd0, pending}, 16'd1);
    chk("digi_pre", {4'd0, digi}, 16'hFFF);
    wait_tick();
    chk("pend_tick", {15'd0, pending}, 16'd1);
    boundary_edge();

    run_frame(16'h1234, 4'h0, 4'hF, 10, 16'hAAAA, 4'h0, 4'hF,
              -1, 16'h0, 4'h0, 4'h0);
    chk("lit_1234", {4'd0, k1_digi}, 16'hE99);
    boundary_edge();

    run_frame(16'hAAAA, 4'h0, 4'hF, 78, 16'h5678, 4'h0, 4'hF,
              79, 16'hCDEB, 4'b0001, 4'b0101);
    chk("lit_AAAA", {4'd0, k1_digi}, 16'hE88);
    boundary_edge();

    run_frame(16'hCDEB, 4'b0001, 4'b0101, 5, 16'h0050, 4'h0, 4'hF,
              -1, 16'h0, 4'h0, 4'h0);
    chk("lit_CDEB", {4'd0, k1_digi}, 16'hE03);
    boundary_edge();

    run_frame(16'h0050, 4'h0, 4'hF, -1, 16'h0, 4'h0, 4'h0,
              -1, 16'h0, 4'h0, 4'h0);
    chk("lit_0050", {4'd0, k1_digi}, 16'hEC0);
    boundary_edge();

    for (int i = 0; i < 5; i++) step();
    wr_set(16'hFFFF, 4'hF, 4'hF);
    step();
    wr = 1'b0;
    chk("pend_mid", {15'd0, pending}, 16'd1);
    reset = 1'b0;
    step();
    step();
    chk("mrst_digi", {4'd0, digi}, 16'hFFF);
    chk("mrst_pend", {15'd0, pending}, 16'd0);
    chk("mrst_tick", {15'd0, frame_tick}, 16'd0);
    reset = 1'b1;
    wait_tick();
    chk("mrst_nopend", {15'd0, pending}, 16'd0);
    boundary_edge();
    run_frame(16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0,
              -1, 16'h0, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
